// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe board slice:
// cell codes, board positions, FSM encoding and small helpers.
package ttt_pkg;

    typedef enum logic [1:0] {
        BLANK = 2'b00,
        HUMAN = 2'b01,
        AI    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'b00,
        ST_CHECK = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [3:0] POS_NONE = 4'd0;
    localparam logic [3:0] POS_A    = 4'd1;
    localparam logic [3:0] POS_B    = 4'd2;
    localparam logic [3:0] POS_C    = 4'd3;
    localparam logic [3:0] POS_D    = 4'd4;
    localparam logic [3:0] POS_E    = 4'd5;
    localparam logic [3:0] POS_F    = 4'd6;
    localparam logic [3:0] POS_G    = 4'd7;
    localparam logic [3:0] POS_H    = 4'd8;
    localparam logic [3:0] POS_I    = 4'd9;

    localparam int         N_CELLS   = 9;
    localparam logic [3:0] MAX_MOVES = 4'd9;

    function automatic logic pos_in_range(input logic [3:0] pos);
        return (pos >= POS_A) && (pos <= POS_I);
    endfunction

    // Board cell index 0..8 (a..i); out-of-range positions map to 0
    // and must be masked by pos_in_range at the caller.
    function automatic logic [3:0] pos_to_idx(input logic [3:0] pos);
        return pos_in_range(pos) ? (pos - 4'd1) : 4'd0;
    endfunction

    function automatic logic [1:0] line_owner(
        input logic [1:0] a,
        input logic [1:0] b,
        input logic [1:0] c
    );
        return ((a != BLANK) && (a == b) && (b == c)) ? a : BLANK;
    endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational line evaluator: reports a three-in-a-row owner
// and whether every cell of the board is occupied.
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [5:0] i_top,
    input  logic [5:0] i_middle,
    input  logic [5:0] i_bottom,
    output logic       o_win,
    output logic [1:0] o_win_code,
    output logic       o_full
);

    logic [1:0] w_c    [0:8];
    logic [1:0] w_line [0:7];

    assign w_c[0] = i_top[5:4];
    assign w_c[1] = i_top[3:2];
    assign w_c[2] = i_top[1:0];
    assign w_c[3] = i_middle[5:4];
    assign w_c[4] = i_middle[3:2];
    assign w_c[5] = i_middle[1:0];
    assign w_c[6] = i_bottom[5:4];
    assign w_c[7] = i_bottom[3:2];
    assign w_c[8] = i_bottom[1:0];

    assign w_line[0] = line_owner(w_c[0], w_c[1], w_c[2]);
    assign w_line[1] = line_owner(w_c[3], w_c[4], w_c[5]);
    assign w_line[2] = line_owner(w_c[6], w_c[7], w_c[8]);
    assign w_line[3] = line_owner(w_c[0], w_c[3], w_c[6]);
    assign w_line[4] = line_owner(w_c[1], w_c[4], w_c[7]);
    assign w_line[5] = line_owner(w_c[2], w_c[5], w_c[8]);
    assign w_line[6] = line_owner(w_c[0], w_c[4], w_c[8]);
    assign w_line[7] = line_owner(w_c[2], w_c[4], w_c[6]);

    // Lowest-numbered winning line wins; in legal play only one
    // player can ever own a line, so the order is immaterial.
    always_comb begin
        o_win      = 1'b0;
        o_win_code = BLANK;
        for (int i = 7; i >= 0; i--) begin
            if (w_line[i] != BLANK) begin
                o_win      = 1'b1;
                o_win_code = w_line[i];
            end
        end
    end

    always_comb begin
        o_full = 1'b1;
        for (int i = 0; i < N_CELLS; i++) begin
            if (w_c[i] == BLANK) begin
                o_full = 1'b0;
            end
        end
    end

endmodule

// File: rtl/board_state_reg.sv
// Tic-tac-toe board register: commits validated moves, tracks the
// turn and move count, and resolves win/draw one cycle later.
module board_state_reg
    import ttt_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       valid_move,
    input  logic [3:0] move_in,
    output logic [5:0] top,
    output logic [5:0] middle,
    output logic [5:0] bottom,
    output logic       human_turn,
    output logic       move_ack,
    output logic       move_reject,
    output logic [3:0] move_count,
    output logic       game_over,
    output logic [1:0] winner
);

    state_t     r_state;
    logic [1:0] r_board [0:8];
    logic       r_human_turn;
    logic       r_ack;
    logic       r_reject;
    logic [3:0] r_count;
    logic       r_over;
    logic [1:0] r_winner;

    logic       w_pos_ok;
    logic [3:0] w_idx;
    logic       w_cell_free;
    logic [1:0] w_player;
    logic       w_win;
    logic [1:0] w_win_code;
    logic       w_full;

    assign w_pos_ok    = pos_in_range(move_in);
    assign w_idx       = pos_to_idx(move_in);
    assign w_cell_free = w_pos_ok && (r_board[w_idx] == BLANK);
    assign w_player    = r_human_turn ? HUMAN : AI;

    assign top    = {r_board[0], r_board[1], r_board[2]};
    assign middle = {r_board[3], r_board[4], r_board[5]};
    assign bottom = {r_board[6], r_board[7], r_board[8]};

    ttt_win_detect u_win_detect (
        .i_top      (top),
        .i_middle   (middle),
        .i_bottom   (bottom),
        .o_win      (w_win),
        .o_win_code (w_win_code),
        .o_full     (w_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_PLAY;
            r_human_turn <= 1'b1;
            r_ack        <= 1'b0;
            r_reject     <= 1'b0;
            r_count      <= 4'd0;
            r_over       <= 1'b0;
            r_winner     <= BLANK;
            for (int i = 0; i < N_CELLS; i++) begin
                r_board[i] <= BLANK;
            end
        end else begin
            r_ack    <= 1'b0;
            r_reject <= 1'b0;
            if (new_game) begin
                r_state      <= ST_PLAY;
                r_human_turn <= 1'b1;
                r_count      <= 4'd0;
                r_over       <= 1'b0;
                r_winner     <= BLANK;
                for (int i = 0; i < N_CELLS; i++) begin
                    r_board[i] <= BLANK;
                end
            end else begin
                unique case (r_state)
                    ST_PLAY: begin
                        if (valid_move) begin
                            if (w_cell_free) begin
                                r_board[w_idx] <= w_player;
                                r_count        <= r_count + 4'd1;
                                r_ack          <= 1'b1;
                                r_state        <= ST_CHECK;
                            end else begin
                                r_reject <= 1'b1;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (valid_move) begin
                            r_reject <= 1'b1;
                        end
                        // The board is full exactly when nine moves
                        // have been committed; either signal suffices.
                        if (w_win) begin
                            r_winner <= w_win_code;
                            r_over   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else if ((r_count == MAX_MOVES) || w_full) begin
                            r_winner <= BLANK;
                            r_over   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_human_turn <= ~r_human_turn;
                            r_state      <= ST_PLAY;
                        end
                    end
                    ST_DONE: begin
                        if (valid_move) begin
                            r_reject <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_PLAY;
                    end
                endcase
            end
        end
    end

    assign human_turn  = r_human_turn;
    assign move_ack    = r_ack;
    assign move_reject = r_reject;
    assign move_count  = r_count;
    assign game_over   = r_over;
    assign winner      = r_winner;

endmodule

// File: doc/board_state_reg.md
# board_state_reg

Holds the 3×3 tic-tac-toe board, whose turn it is, and the game result.
- Sits directly downstream of the move-validation stage.
- Commits each validated move (position 1–9 plus a valid pulse) into the current player's cell, then toggles the turn.
- Evaluates win and draw one cycle after each commit.
- Feeds the packed board rows back to validation, move selection and display.

## Interface
Parameters:
- none (widths fixed by the shared package)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- new_game  in  1  synchronous clear to the empty board; human moves first
- valid_move  in  1  single-cycle strobe: move_in is a validated move
- move_in  in  4  board position, 1=a … 9=i (a b c / d e f / g h i); 0 and 10–15 mean no move
- top  out  6  cells a,b,c at [5:4],[3:2],[1:0]
- middle  out  6  cells d,e,f, same packing
- bottom  out  6  cells g,h,i, same packing
- human_turn  out  1  1 when the human is to move; 0 when the AI is to move
- move_ack  out  1  one-cycle pulse: move committed
- move_reject  out  1  one-cycle pulse: strobe dropped (bad position, occupied cell, busy or game over)
- move_count  out  4  number of committed moves, 0–9
- game_over  out  1  game finished, board locked
- winner  out  2  00 none/draw, 01 human, 10 AI

## Operation
Cell encoding:
- 00 blank
- 01 human (X)
- 10 AI (O)
- 11 never written

FSM states: PLAY, CHECK, DONE.

PLAY:
- On valid_move with move_in in 1..9 and the target cell blank:
  - write the current player's code to that cell
  - move_count +1
  - pulse move_ack
  - go to CHECK
- Any other valid_move: pulse move_reject, no state change.

CHECK:
- Evaluate the 8 lines: 3 rows, 3 columns, 2 diagonals.
- Any line of three equal non-blank cells: winner = that code, game_over=1, go to DONE.
- Else, move_count==9: winner=00, game_over=1, go to DONE.
- Else: toggle human_turn, go to PLAY.
- valid_move arriving in CHECK: move_reject.

DONE:
- Board frozen.
- Every valid_move: move_reject.
- Leaves only on new_game or reset.

new_game:
- Accepted in any state.
- Clears the board, move_count, winner, game_over; sets human_turn=1; enters PLAY.
- Takes priority over a simultaneous valid_move; no ack or reject is issued for that move.

move_count is 4 bits and saturates at 9 by construction (no free cell remains).

## Timing
Reset values:
- all cells 00, so top/middle/bottom = 0
- human_turn=1
- move_ack=0, move_reject=0
- move_count=0
- game_over=0, winner=00
- state PLAY

Latency:
- Strobe sampled on edge N. Cell, move_count and move_ack are visible after edge N.
- game_over, winner and human_turn update after edge N+1.
- Next move accepted from edge N+2.

Handshake and outputs:
- move_ack and move_reject are mutually exclusive and each high exactly one cycle.
- Outputs are registered; no combinational path from inputs to outputs.

Reset mid-operation (including in CHECK) returns everything to the reset values immediately; no partial commit survives.

## Structure
Shared package `ttt_pkg` holds:
- cell codes (BLANK, HUMAN, AI)
- position constants POS_A..POS_I (1–9) and POS_NONE (0)
- the FSM state encoding

Sub-module `ttt_win_detect` is combinational:
- input: the three row buses
- outputs: win (1), win_code (2), full (1)
- instanced once; its outputs are sampled only in CHECK

## Test plan
- Reset, then human 5, AI 1, human 3, AI 9, human 7 → after the last CHECK: winner=01, game_over=1, move_count=5, human_turn unchanged (1), middle=6'b000100 (e=HUMAN).
- Human 1 then AI 1 → second strobe gives move_reject=1; top[5:4] stays 01; move_count=1; human_turn=0.
- Strobes with move_in=0 and move_in=12 → move_reject each; board stays 0.
- Fill the board with the draw sequence 1,2,3,5,4,6,8,7,9 → winner=00, game_over=1, move_count=9; a further valid_move gives move_reject.
- valid_move on the cycle right after an ack (state CHECK) → move_reject; then new_game together with valid_move → board all 0, human_turn=1, no ack or reject.
- Assert reset while in CHECK after a winning move → game_over=0, move_count=0, all rows 0 immediately.
